// File: rtl/alu_ctrl_pkg.sv
// Shared decode constants for the ALU control block: funct codes, ALUCtrl codes,
// multiply/divide FSM states and writeback-source encodings.
// No logic; imported by the top and the multiply/divide datapath.
package alu_ctrl_pkg;

  // Main-control opcode that hands decoding to the funct field
  localparam logic [3:0] OP_RTYPE = 4'hF;

  // R-type funct codes: ALU group
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_XOR  = 6'h05;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // R-type funct codes: HI/LO group
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // ALUCtrl operation codes
  localparam logic [3:0] C_AND  = 4'h0;
  localparam logic [3:0] C_OR   = 4'h1;
  localparam logic [3:0] C_ADD  = 4'h2;
  localparam logic [3:0] C_SLL  = 4'h3;
  localparam logic [3:0] C_SRL  = 4'h4;
  localparam logic [3:0] C_SUB  = 4'h6;
  localparam logic [3:0] C_SLT  = 4'h7;
  localparam logic [3:0] C_ADDU = 4'h8;
  localparam logic [3:0] C_SUBU = 4'h9;
  localparam logic [3:0] C_XOR  = 4'hA;
  localparam logic [3:0] C_SLTU = 4'hB;
  localparam logic [3:0] C_NOR  = 4'hC;
  localparam logic [3:0] C_SRA  = 4'hD;

  // Writeback source select
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, sign fix.
// Latency: WIDTH step cycles after start; fixed-up result is combinational from the regs.
// No backpressure: the owner asserts step every iteration cycle and reads res_* afterwards.
module md_iter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             div_in,
  input  logic             sgn_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             divz
);

  logic [WIDTH-1:0]   acc;      // product high half / partial remainder
  logic [WIDTH-1:0]   sreg;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   dvs;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rs_raw;   // untouched dividend, returned as HI on divide-by-zero
  logic [CNTW-1:0]    cnt;
  logic               is_div;
  logic               neg_q;    // product / quotient must be negated
  logic               neg_r;    // remainder must be negated (follows dividend)

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [WIDTH-1:0]   acc_nxt, sreg_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes for the signed ops; the iteration core is unsigned only
  always_comb begin
    neg_a = sgn_in & a[WIDTH-1];
    neg_b = sgn_in & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
  end

  // One iteration: multiply shifts {acc,sreg} right, divide shifts it left
  always_comb begin
    mul_sum  = {1'b0, acc} + (sreg[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
    div_rem  = {acc, sreg[WIDTH-1]};
    div_diff = div_rem - {1'b0, dvs};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_nxt  = div_diff[WIDTH-1:0];
        sreg_nxt = {sreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = div_rem[WIDTH-1:0];
        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt  = mul_sum[WIDTH:1];
      sreg_nxt = {mul_sum[0], sreg[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CNTW'(WIDTH - 1));

  // Capture operands on start, then advance one bit per step
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sreg   <= '0;
      dvs    <= '0;
      rs_raw <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      sreg   <= mag_a;
      dvs    <= mag_b;
      rs_raw <= a;
      cnt    <= '0;
      is_div <= div_in;
      neg_q  <= neg_a ^ neg_b;
      neg_r  <= neg_a;
      divz   <= div_in & (b == '0);
    end else if (step) begin
      acc  <= acc_nxt;
      sreg <= sreg_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // Sign correction and result selection; divide-by-zero overrides the iteration result
  always_comb begin
    prod     = {acc, sreg};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -sreg : sreg;
    rem_fix  = neg_r ? -acc : acc;
    if (divz) begin
      res_hi = rs_raw;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode plus HI/LO multiply/divide sequencer.
// Latency: decode is combinational; MULT/DIV results land WIDTH+1 cycles after accept.
// Backpressure: stall holds decode only for HI/LO instructions while the engine is busy.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ALUop,
  input  logic [5:0]       FuncCode,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       ALUCtrl,
  output logic [1:0]       hilo_sel,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state;
  logic             hilo_op, is_mthi, is_mtlo, is_md, md_div, md_sgn;
  logic             accept, md_start, md_last;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_divz;

  // Opcode/funct decode into ALU operation, writeback source and HI/LO class
  always_comb begin
    ALUCtrl  = ALUop;
    hilo_sel = SEL_ALU;
    illegal  = 1'b0;
    hilo_op  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    is_md    = 1'b0;
    md_div   = 1'b0;
    md_sgn   = 1'b0;
    if (ALUop == OP_RTYPE) begin
      ALUCtrl = C_AND;
      case (FuncCode)
        F_SLL:   ALUCtrl = C_SLL;
        F_SRL:   ALUCtrl = C_SRL;
        F_SRA:   ALUCtrl = C_SRA;
        F_ADD:   ALUCtrl = C_ADD;
        F_ADDU:  ALUCtrl = C_ADDU;
        F_SUB:   ALUCtrl = C_SUB;
        F_SUBU:  ALUCtrl = C_SUBU;
        F_AND:   ALUCtrl = C_AND;
        F_OR:    ALUCtrl = C_OR;
        F_XOR:   ALUCtrl = C_XOR;
        F_NOR:   ALUCtrl = C_NOR;
        F_SLT:   ALUCtrl = C_SLT;
        F_SLTU:  ALUCtrl = C_SLTU;
        F_MFHI:  begin hilo_op = 1'b1; hilo_sel = SEL_HI; end
        F_MFLO:  begin hilo_op = 1'b1; hilo_sel = SEL_LO; end
        F_MTHI:  begin hilo_op = 1'b1; is_mthi = 1'b1; end
        F_MTLO:  begin hilo_op = 1'b1; is_mtlo = 1'b1; end
        F_MULT:  begin hilo_op = 1'b1; is_md = 1'b1; md_sgn = 1'b1; end
        F_MULTU: begin hilo_op = 1'b1; is_md = 1'b1; end
        F_DIV:   begin hilo_op = 1'b1; is_md = 1'b1; md_div = 1'b1; md_sgn = 1'b1; end
        F_DIVU:  begin hilo_op = 1'b1; is_md = 1'b1; md_div = 1'b1; end
        default: illegal = 1'b1;
      endcase
    end
  end

  // A MULT/DIV can only be accepted while idle, since it stalls otherwise
  assign md_busy  = (state != IDLE);
  assign stall    = valid_in & hilo_op & md_busy;
  assign accept   = valid_in & ~stall;
  assign md_start = accept & is_md;

  md_iter #(.WIDTH(WIDTH), .CNTW(CNTW)) u_md_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .step   (state == ITER),
    .div_in (md_div),
    .sgn_in (md_sgn),
    .a      (rs_val),
    .b      (rt_val),
    .last   (md_last),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .divz   (res_divz)
  );

  // Sequencer: IDLE -> WIDTH cycles of ITER -> one FIX cycle -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (md_start) state <= ITER;
        ITER:    if (md_last)  state <= FIX;
        FIX:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // HI/LO: written by the FIX cycle or directly by MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (accept && is_mthi) hi <= rs_val;
      if (accept && is_mtlo) lo <= rs_val;
    end
  end

  // Completion pulse and sticky divide-by-zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      md_done <= 1'b0;
      div0    <= 1'b0;
    end else begin
      md_done <= (state == FIX);
      if (md_start)
        div0 <= 1'b0;
      else if (state == FIX && res_divz)
        div0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Randomised and directed check of alu_control_md against a behavioural model.
// Expected HI/LO results are queued at issue and popped by a monitor on md_done.
// Decode and stall outputs are compared in the cycle they are driven.
module tb_alu_control_md;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ALUop;
  logic [5:0]   FuncCode;
  logic         valid_in;
  logic [W-1:0] rs_val, rt_val;
  logic [3:0]   ALUCtrl;
  logic [1:0]   hilo_sel;
  logic         illegal, stall, md_busy, md_done, div0;
  logic [W-1:0] hi, lo;

  alu_control_md #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ALUop(ALUop), .FuncCode(FuncCode), .valid_in(valid_in),
    .rs_val(rs_val), .rt_val(rt_val), .ALUCtrl(ALUCtrl), .hilo_sel(hilo_sel),
    .illegal(illegal), .stall(stall), .md_busy(md_busy), .md_done(md_done),
    .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         d0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division
  task automatic model(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    longint      sa, sbv, p, q, r;
    logic [63:0] up;
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (fn)
      F_MULT: begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        p = sa * sbv;
        eh = p[63:32];
        el = p[31:0];
      end
      F_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      default: begin
        if (b == 0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
          ed = 1'b1;
        end else if (fn == F_DIV) begin
          sa = longint'($signed(a));
          sbv = longint'($signed(b));
          q = sa / sbv;
          r = sa % sbv;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  // Reference decode table
  task automatic ref_dec(input logic [3:0] op, input logic [5:0] fn,
                         output logic [3:0] c, output logic [1:0] s, output logic ill);
    c = op; s = 2'b00; ill = 1'b0;
    if (op == 4'hF) begin
      c = 4'h0;
      case (fn)
        6'h00: c = 4'h3;  6'h02: c = 4'h4;  6'h03: c = 4'hD;  6'h20: c = 4'h2;
        6'h21: c = 4'h8;  6'h22: c = 4'h6;  6'h23: c = 4'h9;  6'h24: c = 4'h0;
        6'h25: c = 4'h1;  6'h05: c = 4'hA;  6'h27: c = 4'hC;  6'h2A: c = 4'h7;
        6'h2B: c = 4'hB;
        6'h10: s = 2'b01;
        6'h12: s = 2'b10;
        6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: ;
        default: ill = 1'b1;
      endcase
    end
  endtask

  // Monitor: every md_done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && md_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: md_done=1 with nothing outstanding at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("md_hi", hi, mon_e.hi);
        chk("md_lo", lo, mon_e.lo);
        chk("md_div0", div0, mon_e.d0);
      end
    end
  end

  // Drive a MULT/DIV for one cycle (entered just after a negedge); returns in T+1
  task automatic start_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    model(fn, a, b, e.hi, e.lo, e.d0);
    ALUop = 4'hF; FuncCode = fn; rs_val = a; rt_val = b; valid_in = 1'b1;
    #1 chk("md_issue_nostall", stall, 0);
    sb.push_back(e);
    @(negedge clk);
    valid_in = 1'b0; ALUop = 4'h0; FuncCode = 6'h00;
    #1 chk("div0_cleared_on_accept", div0, 0);
  endtask

  // Count busy cycles until md_done (bounded), then confirm the pulse is single
  task automatic wait_idle(input int exp_busy);
    int n = 0;
    int busy = 0;
    while (!md_done && n < 100) begin
      if (md_busy) busy++;
      @(negedge clk);
      n++;
    end
    chk("md_done_seen", md_done, 1);
    chk("busy_cycles", busy, exp_busy);
    @(negedge clk);
    chk("done_single_pulse", md_done, 0);
    chk("busy_low_after_done", md_busy, 0);
  endtask

  task automatic issue_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    start_md(fn, a, b);
    wait_idle(W + 1);
  endtask

  logic [3:0] d_op [8] = '{4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h5};
  logic [5:0] d_fn [8] = '{6'h3F, 6'h23, 6'h2B, 6'h3F, 6'h10, 6'h12, 6'h27, 6'h05};

  initial begin
    logic [3:0]   ec;
    logic [1:0]   es;
    logic         ei;
    logic [5:0]   fn;
    logic [5:0]   md_fns [4];
    logic [W-1:0] a, b;
    exp_t         e;
    int           held;

    md_fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    rst = 1'b1; valid_in = 1'b0; ALUop = 4'h0; FuncCode = 6'h00; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_div0", div0, 0);
    rst = 1'b0;

    // Decode: directed table then random opcodes/functs (never valid, so nothing issues)
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ALUop = d_op[i]; FuncCode = d_fn[i];
      ref_dec(ALUop, FuncCode, ec, es, ei);
      #1;
      chk("dec_ctrl", ALUCtrl, ec);
      chk("dec_sel", hilo_sel, es);
      chk("dec_illegal", illegal, ei);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ALUop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) ALUop = 4'hF;
      FuncCode = 6'($urandom_range(0, 63));
      ref_dec(ALUop, FuncCode, ec, es, ei);
      #1;
      chk("rdec_ctrl", ALUCtrl, ec);
      chk("rdec_sel", hilo_sel, es);
      chk("rdec_illegal", illegal, ei);
    end
    @(negedge clk);
    ALUop = 4'h0; FuncCode = 6'h00;

    // Directed multiply/divide cases
    @(negedge clk);
    issue_md(F_MULT,  32'hFFFF_FFFD, 32'd7);
    issue_md(F_DIVU,  32'd100, 32'd7);
    issue_md(F_DIV,   32'hFFFF_FFF9, 32'd2);
    issue_md(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue_md(F_DIV,   32'd5, 32'd0);
    chk("div0_sticky", div0, 1);
    issue_md(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);

    // MTHI/MTLO write in one cycle; MFHI selects HI
    ALUop = 4'hF; FuncCode = F_MTHI; rs_val = 32'hCAFE_0001; valid_in = 1'b1;
    @(negedge clk);
    chk("mthi", hi, 32'hCAFE_0001);
    FuncCode = F_MTLO; rs_val = 32'hBEEF_0002;
    @(negedge clk);
    chk("mtlo", lo, 32'hBEEF_0002);
    FuncCode = F_MFHI;
    #1 chk("mfhi_sel", hilo_sel, 2'b01);
    @(negedge clk);
    valid_in = 1'b0;

    // MFLO held behind a MULT: stalled T+3..T+33, accepted T+34
    @(negedge clk);
    a = 32'h0001_0003; b = 32'hFFFF_0005;
    model(F_MULT, a, b, e.hi, e.lo, e.d0);
    start_md(F_MULT, a, b);
    repeat (2) @(negedge clk);
    ALUop = 4'hF; FuncCode = F_MFLO; valid_in = 1'b1;
    held = 0;
    for (int c = 3; c <= W + 1; c++) begin
      #1 if (stall) held++;
      @(negedge clk);
    end
    #1;
    chk("mflo_stall_cycles", held, W - 1);
    chk("mflo_released", stall, 0);
    chk("mflo_sel", hilo_sel, 2'b10);
    chk("mflo_value", lo, e.lo);
    @(negedge clk);
    valid_in = 1'b0; ALUop = 4'h0; FuncCode = 6'h00;
    @(negedge clk);

    // ALU op during busy is not stalled
    start_md(F_MULTU, 32'd9, 32'd11);
    repeat (4) @(negedge clk);
    ALUop = 4'hF; FuncCode = F_ADD; valid_in = 1'b1;
    #1;
    chk("add_busy_nostall", stall, 0);
    chk("add_busy_ctrl", ALUCtrl, 4'h2);
    @(negedge clk);
    valid_in = 1'b0; ALUop = 4'h0; FuncCode = 6'h00;
    wait_idle(W + 1 - 5);

    // Reset in the middle of a divide discards it
    start_md(F_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", md_busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    repeat (40) @(negedge clk);
    issue_md(F_MULTU, 32'hFFFF_FFFF, 32'd2);

    // Random multiply/divide traffic with corner operands mixed in
    for (int i = 0; i < 20; i++) begin
      fn = md_fns[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue_md(fn, a, b);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised ALU control for the single-cycle datapath, extended with HI/LO multiply/divide sequencing. It decodes `ALUop` and `FuncCode` into the 4-bit `ALUCtrl` as before. It also owns an iterative multiply/divide engine with HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. While that engine is busy, it stalls only the instructions that touch HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; must be even and ≥4.
- `CNTW`, `$clog2(WIDTH+1)`: iteration counter width (derived; do not override).

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `ALUop`  in  4  — main-control opcode; `4'b1111` selects funct decode.
- `FuncCode`  in  6  — R-type funct field.
- `valid_in`  in  1  — instruction in decode this cycle.
- `rs_val`, `rt_val`  in  WIDTH  — register operands.
- `ALUCtrl`  out  4  — ALU operation, combinational.
- `hilo_sel`  out  2  — writeback source: 00 ALU, 01 HI, 10 LO.
- `illegal`  out  1  — unknown funct under `ALUop=1111`, combinational.
- `stall`  out  1  — hold PC/decode, combinational.
- `md_busy`  out  1  — engine iterating; registered.
- `md_done`  out  1  — one-cycle pulse in the first cycle new HI/LO is visible.
- `div0`  out  1  — last DIV/DIVU had a zero divisor (sticky).
- `hi`, `lo`  out  WIDTH  — HI/LO registers.

## Operation
- `ALUop != 1111`: `ALUCtrl = ALUop`, `hilo_sel = 00`.
- Funct map, values in hex:
  - ALU functs: SLL 00→3, SRL 02→4, SRA 03→D, ADD 20→2, ADDU 21→8, SUB 22→6, SUBU 23→9, AND 24→0, OR 25→1, XOR 05→A, NOR 27→C, SLT 2A→7, SLTU 2B→B.
  - HI/LO functs: MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B. These produce `ALUCtrl=0`. MFHI gives `hilo_sel=01`; MFLO gives `hilo_sel=10`.
  - Any other funct: `ALUCtrl=0`, `illegal=1`.
- `stall = valid_in & hilo_op & md_busy`, where `hilo_op` covers any of the eight HI/LO functs. ALU ops never stall.
- Accept condition: `valid_in & ~stall`.
  - MTHI/MTLO accepted: HI/LO ← `rs_val` at that edge.
  - MULT*/DIV* accepted: operands captured, `div0` cleared, FSM leaves IDLE.
- FSM states:
  - IDLE → ITER on an accepted MULT*/DIV*.
  - ITER runs exactly WIDTH cycles: shift-add for multiply, restoring divide for divide. It works on unsigned magnitudes (absolute values for the signed ops), then goes to FIX.
  - FIX: applies sign correction and writes HI/LO, then → IDLE.
- Signed results:
  - Product sign is `rs^rt`; HI:LO holds the 2·WIDTH-bit product.
  - Quotient sign is `rs^rt`; remainder sign follows `rs`.
  - Most-negative ÷ −1: LO = most-negative, HI = 0; no trap.
- Divide by zero: LO = all ones, HI = `rs_val` as captured, `div0=1`. The op still takes full latency.
- Reset, including mid-operation:
  - State IDLE, counter 0.
  - `hi=lo=0`, `md_busy=0`, `md_done=0`, `div0=0`.
  - An in-flight result is discarded.

## Timing
- `ALUCtrl`, `hilo_sel`, `illegal` and `stall` are same-cycle combinational.
- MULT*/DIV* accepted in cycle T:
  - `md_busy` is high T+1 … T+WIDTH+1; that is WIDTH ITER cycles plus the FIX cycle.
  - HI/LO are updated at the end of T+WIDTH+1.
  - `md_done` is high in T+WIDTH+2, and `md_busy` is low from then on.
- A HI/LO op issued in T+WIDTH+2 is not stalled and reads the new value.
- A HI/LO op issued in cycle T itself is not stalled (`md_busy` is still 0). It cannot be a second issue, because decode carries one instruction per cycle.
- MTHI/MTLO has 1-cycle latency.

## Structure
- Package `alu_ctrl_pkg`:
  - funct localparams and ALUCtrl code localparams;
  - FSM state enum {IDLE, ITER, FIX};
  - `hilo_sel` encodings.
- Sub-module `md_iter`: the WIDTH-parametrised multiply/divide datapath (accumulator, shift register, counter, sign fix).
- Top level: decode, stall logic, FSM, HI/LO registers.

## Test plan
- Decode:
  - `ALUop=0010` → `ALUCtrl=2`.
  - `ALUop=1111` with funct 23 → 9, funct 2B → B, funct 3F → `illegal=1`, `ALUCtrl=0`.
- MULT rs=0xFFFFFFFD (−3), rt=7 → after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; exactly one `md_done` pulse.
- Divides:
  - DIVU 100/7 → LO=14, HI=2.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 5/0 → LO=0xFFFFFFFF, HI=5, `div0=1`. A following MULTU clears `div0` in its accept cycle.
- Stall behaviour after MULT at T:
  - MFLO held from T+3 → `stall=1` through T+33, accepted at T+34, `hilo_sel=10`, LO correct.
  - ADD issued at T+5 → `stall=0`.
- Reset recovery:
  - `rst` at T+10 of a DIV → next cycle `md_busy=0`, `hi=lo=0`.
  - Then MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
